// File: rtl/id_funct_decoder_pipe_pkg.sv
// Shared encodings for the ID-stage ALU FUNCT decoder: opcode, funct, SPECIAL2 and REGIMM fields.
package id_funct_decoder_pipe_pkg;

  localparam int OP_W    = 6;
  localparam int FUNCT_W = 6;
  localparam int RT_W    = 5;

  // op_def
  localparam logic [OP_W-1:0] OP_SPECIAL  = 6'h00;
  localparam logic [OP_W-1:0] OP_REGIMM   = 6'h01;
  localparam logic [OP_W-1:0] OP_J        = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL      = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ      = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE      = 6'h05;
  localparam logic [OP_W-1:0] OP_BLEZ     = 6'h06;
  localparam logic [OP_W-1:0] OP_BGTZ     = 6'h07;
  localparam logic [OP_W-1:0] OP_ADDI     = 6'h08;
  localparam logic [OP_W-1:0] OP_ADDIU    = 6'h09;
  localparam logic [OP_W-1:0] OP_SLTI     = 6'h0a;
  localparam logic [OP_W-1:0] OP_SLTIU    = 6'h0b;
  localparam logic [OP_W-1:0] OP_ANDI     = 6'h0c;
  localparam logic [OP_W-1:0] OP_ORI      = 6'h0d;
  localparam logic [OP_W-1:0] OP_XORI     = 6'h0e;
  localparam logic [OP_W-1:0] OP_LUI      = 6'h0f;
  localparam logic [OP_W-1:0] OP_SPECIAL2 = 6'h1c;
  localparam logic [OP_W-1:0] OP_LB       = 6'h20;
  localparam logic [OP_W-1:0] OP_LH       = 6'h21;
  localparam logic [OP_W-1:0] OP_LW       = 6'h23;
  localparam logic [OP_W-1:0] OP_LBU      = 6'h24;
  localparam logic [OP_W-1:0] OP_LHU      = 6'h25;
  localparam logic [OP_W-1:0] OP_SB       = 6'h28;
  localparam logic [OP_W-1:0] OP_SH       = 6'h29;
  localparam logic [OP_W-1:0] OP_SW       = 6'h2b;

  // funct_def
  localparam logic [FUNCT_W-1:0] FUNCT_NOP  = 6'h00;
  localparam logic [FUNCT_W-1:0] FUNCT_ADD  = 6'h20;
  localparam logic [FUNCT_W-1:0] FUNCT_ADDU = 6'h21;
  localparam logic [FUNCT_W-1:0] FUNCT_AND  = 6'h24;
  localparam logic [FUNCT_W-1:0] FUNCT_OR   = 6'h25;
  localparam logic [FUNCT_W-1:0] FUNCT_XOR  = 6'h26;
  localparam logic [FUNCT_W-1:0] FUNCT_SLT  = 6'h2a;
  localparam logic [FUNCT_W-1:0] FUNCT_SLTU = 6'h2b;

  localparam logic [FUNCT_W-1:0] FUNCT2_MUL = 6'h02;
  localparam logic [FUNCT_W-1:0] FUNCT2_CLZ = 6'h20;
  localparam logic [FUNCT_W-1:0] FUNCT2_CLO = 6'h21;

  // regimm_def
  localparam logic [RT_W-1:0] RT_BLTZ   = 5'h00;
  localparam logic [RT_W-1:0] RT_BGEZ   = 5'h01;
  localparam logic [RT_W-1:0] RT_BLTZAL = 5'h10;
  localparam logic [RT_W-1:0] RT_BGEZAL = 5'h11;

endpackage

// File: rtl/funct_lane_dec.sv
// Single-lane combinational decode of op/funct/rt into the ALU FUNCT code and reserved flag.
module funct_lane_dec
  import id_funct_decoder_pipe_pkg::*;
#(
  parameter int EN_SPECIAL2    = 1,
  parameter int EN_REGIMM_LINK = 1
) (
  input  logic               lane_en,
  input  logic [OP_W-1:0]    op,
  input  logic [FUNCT_W-1:0] funct_in,
  input  logic [RT_W-1:0]    rt,
  output logic [FUNCT_W-1:0] funct,
  output logic               ri
);

  always_comb begin
    funct = FUNCT_NOP;
    ri    = 1'b0;
    if (lane_en) begin
      case (op)
        OP_SPECIAL: funct = funct_in;
        OP_SPECIAL2: begin
          if (EN_SPECIAL2 != 0) begin
            case (funct_in)
              FUNCT2_MUL: funct = FUNCT2_MUL;
              FUNCT2_CLZ: funct = FUNCT2_CLZ;
              FUNCT2_CLO: funct = FUNCT2_CLO;
              default:    ri = 1'b1;
            endcase
          end else begin
            ri = 1'b1;
          end
        end
        OP_ORI, OP_LUI, OP_JAL: funct = FUNCT_OR;
        OP_ANDI:                funct = FUNCT_AND;
        OP_XORI:                funct = FUNCT_XOR;
        OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW,
        OP_SB, OP_SH, OP_SW, OP_ADDI:  funct = FUNCT_ADD;
        OP_ADDIU:               funct = FUNCT_ADDU;
        OP_SLTI:                funct = FUNCT_SLT;
        OP_SLTIU:               funct = FUNCT_SLTU;
        OP_REGIMM: begin
          case (rt)
            // Linking branches write the return address through the ALU OR path.
            RT_BLTZAL, RT_BGEZAL: funct = (EN_REGIMM_LINK != 0) ? FUNCT_OR : FUNCT_NOP;
            RT_BLTZ, RT_BGEZ:     funct = FUNCT_NOP;
            default:              ri = 1'b1;
          endcase
        end
        OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_J: funct = FUNCT_NOP;
        default: ri = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/id_funct_decoder_pipe.sv
// Multi-lane ALU FUNCT decoder with a registered valid/ready output and one-entry skid buffer.
module id_funct_decoder_pipe
  import id_funct_decoder_pipe_pkg::*;
#(
  parameter int LANES          = 1,
  parameter int EN_SPECIAL2    = 1,
  parameter int EN_REGIMM_LINK = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES-1:0]         in_lane_en,
  input  logic [LANES*OP_W-1:0]    op,
  input  logic [LANES*FUNCT_W-1:0] funct_in,
  input  logic [LANES*RT_W-1:0]    rt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*FUNCT_W-1:0] funct,
  output logic [LANES-1:0]         ri,
  output logic [LANES-1:0]         out_lane_en
);

  // Stage p0: combinational per-lane decode
  logic [LANES*FUNCT_W-1:0] funct_p0;
  logic [LANES-1:0]         ri_p0;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    funct_lane_dec #(
      .EN_SPECIAL2   (EN_SPECIAL2),
      .EN_REGIMM_LINK(EN_REGIMM_LINK)
    ) u_dec (
      .lane_en (in_lane_en[i]),
      .op      (op[i*OP_W +: OP_W]),
      .funct_in(funct_in[i*FUNCT_W +: FUNCT_W]),
      .rt      (rt[i*RT_W +: RT_W]),
      .funct   (funct_p0[i*FUNCT_W +: FUNCT_W]),
      .ri      (ri_p0[i])
    );
  end

  // Stage p1: output register plus skid entry
  logic [LANES*FUNCT_W-1:0] funct_p1, funct_skd;
  logic [LANES-1:0]         ri_p1, ri_skd, len_p1, len_skd;
  logic                     vld_p1, skid_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      skid_full <= 1'b0;
      funct_p1  <= '0;
      ri_p1     <= '0;
      len_p1    <= '0;
      funct_skd <= '0;
      ri_skd    <= '0;
      len_skd   <= '0;
    end else if (flush) begin
      vld_p1    <= 1'b0;
      skid_full <= 1'b0;
    end else if (!vld_p1 || out_ready) begin
      // Output slot frees up: the skid has priority since it is older; the
      // input is only accepted here when the skid was already empty.
      if (skid_full) begin
        funct_p1  <= funct_skd;
        ri_p1     <= ri_skd;
        len_p1    <= len_skd;
        vld_p1    <= 1'b1;
        skid_full <= 1'b0;
      end else if (in_valid) begin
        funct_p1 <= funct_p0;
        ri_p1    <= ri_p0;
        len_p1   <= in_lane_en;
        vld_p1   <= 1'b1;
      end else begin
        vld_p1 <= 1'b0;
      end
    end else if (in_valid && !skid_full) begin
      funct_skd <= funct_p0;
      ri_skd    <= ri_p0;
      len_skd   <= in_lane_en;
      skid_full <= 1'b1;
    end
  end

  assign in_ready    = !skid_full;
  assign out_valid   = vld_p1;
  assign funct       = funct_p1;
  assign ri          = ri_p1;
  assign out_lane_en = len_p1;

endmodule

// File: tb/tb_id_funct_decoder_pipe.sv
// Directed self-checking bench: two-lane decoder plus a single-lane variant with SPECIAL2 and link disabled.
module tb_id_funct_decoder_pipe;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [1:0]  in_lane_en;
  logic [11:0] op, funct_in;
  logic [9:0]  rt;
  logic        in_ready, out_valid;
  logic [11:0] funct;
  logic [1:0]  ri, out_lane_en;

  logic [0:0]  b_in_lane_en;
  logic [5:0]  b_op, b_funct_in;
  logic [4:0]  b_rt;
  logic        b_in_ready, b_out_valid;
  logic [5:0]  b_funct;
  logic [0:0]  b_ri, b_out_lane_en;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_funct_decoder_pipe #(.LANES(2), .EN_SPECIAL2(1), .EN_REGIMM_LINK(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_lane_en(in_lane_en), .op(op), .funct_in(funct_in), .rt(rt),
    .out_valid(out_valid), .out_ready(out_ready), .funct(funct), .ri(ri),
    .out_lane_en(out_lane_en)
  );

  id_funct_decoder_pipe #(.LANES(1), .EN_SPECIAL2(0), .EN_REGIMM_LINK(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_lane_en(b_in_lane_en), .op(b_op), .funct_in(b_funct_in), .rt(b_rt),
    .out_valid(b_out_valid), .out_ready(out_ready), .funct(b_funct), .ri(b_ri),
    .out_lane_en(b_out_lane_en)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [1:0] en, input logic [5:0] op1, input logic [5:0] op0,
                     input logic [5:0] f1, input logic [5:0] f0,
                     input logic [4:0] rt1, input logic [4:0] rt0);
    in_lane_en = en;
    op         = {op1, op0};
    funct_in   = {f1, f0};
    rt         = {rt1, rt0};
  endtask

  task automatic drv_b(input logic [5:0] o, input logic [5:0] f, input logic [4:0] r);
    b_in_lane_en = 1'b1;
    b_op         = o;
    b_funct_in   = f;
    b_rt         = r;
  endtask

  initial begin
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drv(2'b00, 6'h00, 6'h00, 6'h00, 6'h00, 5'h00, 5'h00);
    b_in_lane_en = 1'b0; b_op = '0; b_funct_in = '0; b_rt = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_funct", funct, 0);
    chk("reset_ri", ri, 0);
    chk("reset_lane_en", out_lane_en, 0);
    chk("reset_in_ready", in_ready, 1);
    step();
    step();
    rst_n = 1'b1;

    // ORI on lane0, LW on lane1
    in_valid = 1'b1;
    drv(2'b11, 6'h23, 6'h0d, 6'h00, 6'h00, 5'h00, 5'h00);
    drv_b(6'h1c, 6'h02, 5'h00);
    step();
    chk("ori_lw_valid", out_valid, 1);
    chk("ori_lw_funct", funct, 12'h825);
    chk("ori_lw_ri", ri, 2'b00);
    chk("ori_lw_lane_en", out_lane_en, 2'b11);
    chk("b_special2_off_funct", b_funct, 6'h00);
    chk("b_special2_off_ri", b_ri, 1'b1);

    // SPECIAL2 MUL on lane0, CLZ on lane1
    drv(2'b11, 6'h1c, 6'h1c, 6'h20, 6'h02, 5'h00, 5'h00);
    drv_b(6'h01, 6'h00, 5'h10);
    step();
    chk("special2_funct", funct, 12'h802);
    chk("special2_ri", ri, 2'b00);
    chk("b_regimm_link_off_funct", b_funct, 6'h00);
    chk("b_regimm_link_off_ri", b_ri, 1'b0);

    // REGIMM BLTZAL lane0, BLTZ lane1
    drv(2'b11, 6'h01, 6'h01, 6'h00, 6'h00, 5'h00, 5'h10);
    drv_b(6'h00, 6'h2a, 5'h00);
    step();
    chk("regimm_link_funct", funct, 12'h025);
    chk("regimm_link_ri", ri, 2'b00);
    chk("b_special_funct", b_funct, 6'h2a);

    // REGIMM reserved rt lane0, undecoded op lane1; SPECIAL2 unknown funct on b
    drv(2'b11, 6'h3f, 6'h01, 6'h00, 6'h00, 5'h00, 5'h1f);
    drv_b(6'h1c, 6'h21, 5'h00);
    step();
    chk("reserved_funct", funct, 12'h000);
    chk("reserved_ri", ri, 2'b11);
    chk("b_clo_off_ri", b_ri, 1'b1);

    // Lane1 disabled despite an undecoded opcode
    drv(2'b01, 6'h3f, 6'h0f, 6'h00, 6'h00, 5'h00, 5'h00);
    step();
    chk("lane_off_funct", funct, 12'h025);
    chk("lane_off_ri", ri, 2'b00);
    chk("lane_off_lane_en", out_lane_en, 2'b01);

    // No lanes present still yields a valid beat
    drv(2'b00, 6'h3f, 6'h3f, 6'h00, 6'h00, 5'h00, 5'h00);
    step();
    chk("no_lane_valid", out_valid, 1);
    chk("no_lane_ri", ri, 2'b00);
    chk("no_lane_lane_en", out_lane_en, 2'b00);

    // ADDIU lane0, SLTIU lane1
    drv(2'b11, 6'h0b, 6'h09, 6'h00, 6'h00, 5'h00, 5'h00);
    step();
    chk("addiu_sltiu_funct", funct, 12'hae1);

    in_valid = 1'b0;
    step();
    chk("idle_out_valid", out_valid, 0);

    // Backpressure: A, then B into skid, C held off
    in_valid = 1'b1;
    drv(2'b11, 6'h0e, 6'h0c, 6'h00, 6'h00, 5'h00, 5'h00);
    step();
    chk("bp_a_out", funct, 12'h9a4);
    out_ready = 1'b0;
    drv(2'b11, 6'h08, 6'h0a, 6'h00, 6'h00, 5'h00, 5'h00);
    step();
    chk("bp_a_hold", funct, 12'h9a4);
    chk("bp_a_valid", out_valid, 1);
    chk("bp_skid_in_ready", in_ready, 0);
    drv(2'b11, 6'h00, 6'h2b, 6'h22, 6'h00, 5'h00, 5'h00);
    step();
    chk("bp_a_hold2", funct, 12'h9a4);
    chk("bp_c_held_off", in_ready, 0);
    out_ready = 1'b1;
    step();
    chk("bp_b_out", funct, 12'h82a);
    chk("bp_b_valid", out_valid, 1);
    chk("bp_skid_drained", in_ready, 1);
    step();
    chk("bp_c_out", funct, 12'h8a0);
    chk("bp_c_valid", out_valid, 1);
    in_valid = 1'b0;
    step();
    chk("bp_no_dup", out_valid, 0);

    // Flush with output and skid both full
    in_valid = 1'b1;
    out_ready = 1'b0;
    drv(2'b11, 6'h0d, 6'h0d, 6'h00, 6'h00, 5'h00, 5'h00);
    step();
    drv(2'b11, 6'h23, 6'h23, 6'h00, 6'h00, 5'h00, 5'h00);
    step();
    chk("fl_skid_full", in_ready, 0);
    flush = 1'b1;
    drv(2'b11, 6'h0e, 6'h0e, 6'h00, 6'h00, 5'h00, 5'h00);
    step();
    chk("fl_out_valid", out_valid, 0);
    chk("fl_in_ready", in_ready, 1);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("fl_nothing_after", out_valid, 0);

    // Flush discards a beat that would otherwise be accepted
    in_valid = 1'b1;
    drv(2'b11, 6'h0c, 6'h0c, 6'h00, 6'h00, 5'h00, 5'h00);
    flush = 1'b1;
    step();
    chk("fl_drop_input", out_valid, 0);
    flush = 1'b0;
    in_valid = 1'b0;
    step();
    chk("fl_drop_input2", out_valid, 0);

    // Asynchronous reset mid-stream with output and skid full
    in_valid = 1'b1;
    out_ready = 1'b0;
    drv(2'b11, 6'h3f, 6'h0d, 6'h00, 6'h00, 5'h00, 5'h00);
    step();
    chk("ar_pre_ri", ri, 2'b10);
    drv(2'b11, 6'h23, 6'h23, 6'h00, 6'h00, 5'h00, 5'h00);
    step();
    chk("ar_pre_skid", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", out_valid, 0);
    chk("ar_funct", funct, 0);
    chk("ar_ri", ri, 0);
    chk("ar_lane_en", out_lane_en, 0);
    chk("ar_in_ready", in_ready, 1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    chk("ar_no_survivor", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
